// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams a burst from a synchronous-read RAM over a valid/ready channel.
// Optional RAM_READER_BOUNDS_CHECK_EN rejects bursts that would run past the top address.
module ram_burst_reader #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
`ifdef RAM_READER_BOUNDS_CHECK_EN
    ,
    output logic              req_err
`endif
);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              cap, cap_last;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              accept, pop, bound_err;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef RAM_READER_BOUNDS_CHECK_EN
    logic [ADDR_W:0] span;
    assign span      = {1'b0, req_addr} + {1'b0, req_len};
    assign bound_err = span[ADDR_W];
`else
    assign bound_err = 1'b0;
`endif

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = req_valid && req_ready;
    assign mem_addr  = ptr;
    // Reads in flight plus buffered beats never exceed the buffer, so capture never overflows.
    assign mem_rd_en = state == ISSUE && remaining != '0 && (int'(count) + int'(cap) < FIFO_DEPTH);
    assign rsp_valid = count != '0;
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_last  = rsp_valid && fifo_last[rd_ptr];
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (cap) fifo_data[wr_ptr] <= mem_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            cap       <= 1'b0;
            cap_last  <= 1'b0;
            fifo_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
`ifdef RAM_READER_BOUNDS_CHECK_EN
            req_err   <= 1'b0;
`endif
        end else begin
            cap      <= mem_rd_en;
            cap_last <= mem_rd_en && remaining == (ADDR_W+1)'(1);
            if (mem_rd_en) begin
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (cap) begin
                fifo_last[wr_ptr] <= cap_last;
                wr_ptr            <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(cap) - CW'(pop);
`ifdef RAM_READER_BOUNDS_CHECK_EN
            req_err <= accept && bound_err;
`endif
            case (state)
                IDLE: if (accept) begin
                    ptr       <= req_addr;
                    remaining <= {1'b0, req_len} + (ADDR_W+1)'(1);
                    state     <= bound_err ? ERR : ISSUE;
                end
                ISSUE: if (mem_rd_en && remaining == (ADDR_W+1)'(1)) state <= DRAIN;
                DRAIN: if (pop && rsp_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed scenarios for ram_burst_reader against a 16x8 synchronous-read RAM model.
module tb_ram_burst_reader;
    logic       clk = 0, rst_n = 0, req_valid = 0, req_ready, rsp_ready = 1;
    logic [3:0] req_addr = 0, req_len = 0, mem_addr;
    logic       mem_rd_en, rsp_valid, rsp_last, busy;
    logic [7:0] mem_rd_data = 0, rsp_data;
`ifdef RAM_READER_BOUNDS_CHECK_EN
    logic       req_err;
`endif
    logic [7:0] ram [16];
    int         n_checks = 0, n_fail = 0;
    logic [7:0] got_d [32];
    logic       got_l [32];
    int         got_n, first_c, last_c, stall_err, occ_err, rd_seen;

    ram_burst_reader dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
`ifdef RAM_READER_BOUNDS_CHECK_EN
        , .req_err(req_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    task automatic send(input logic [3:0] a, input logic [3:0] l);
        @(negedge clk);
        req_valid = 1; req_addr = a; req_len = l;
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    // Records every accepted beat over a fixed window starting the cycle after acceptance.
    task automatic collect(input int cycles, input bit rnd);
        int issued = 0, popped = 0;
        bit stalled = 0;
        logic [7:0] pd = 0;
        logic pl = 0;
        got_n = 0; first_c = -1; last_c = -1; stall_err = 0; occ_err = 0; rd_seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mem_rd_en && issued - popped >= 3) occ_err++;
            if (stalled && (rsp_data !== pd || rsp_last !== pl)) stall_err++;
            if (mem_rd_en) begin issued++; rd_seen++; end
            if (rsp_valid && rsp_ready) begin
                if (got_n < 32) begin got_d[got_n] = rsp_data; got_l[got_n] = rsp_last; end
                got_n++; popped++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            stalled = rsp_valid && !rsp_ready; pd = rsp_data; pl = rsp_last;
        end
        rsp_ready = 1;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if ({req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_last, busy} !== {1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_outputs: got rdy=%b rd=%b addr=%h v=%b d=%h l=%b busy=%b", req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_last, busy);
        end
`ifdef RAM_READER_BOUNDS_CHECK_EN
        n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL reset_req_err: got %b expected 0", req_err); end
`endif
        @(negedge clk); rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single;
        send(4'd2, 4'd0);
        @(negedge clk);
        n_checks++; if ({mem_rd_en, mem_addr, busy, req_ready} !== {1'b1, 4'd2, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_t1: got rd=%b addr=%h busy=%b rdy=%b expected 1 2 1 0", mem_rd_en, mem_addr, busy, req_ready);
        end
        @(negedge clk);
        n_checks++; if ({rsp_valid, mem_rd_en} !== 2'b00) begin
            n_fail++; $display("FAIL single_t2: got v=%b rd=%b expected 0 0", rsp_valid, mem_rd_en);
        end
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_data, rsp_last} !== {1'b1, 8'h12, 1'b1}) begin
            n_fail++; $display("FAIL single_t3: got v=%b d=%h l=%b expected 1 12 1", rsp_valid, rsp_data, rsp_last);
        end
        @(negedge clk);
        n_checks++; if ({req_ready, busy, rsp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL single_idle: got rdy=%b busy=%b v=%b expected 1 0 0", req_ready, busy, rsp_valid);
        end
    endtask

    task automatic test_full_burst;
        send(4'd0, 4'd15);
        collect(30, 0);
        n_checks++; if (got_n !== 16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", got_n); end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (got_d[i] !== 8'(8'h10 + i) || got_l[i] !== (i == 15)) begin
                n_fail++; $display("FAIL full_beat%0d: got d=%h l=%b expected %h %b", i, got_d[i], got_l[i], 8'(8'h10 + i), i == 15);
            end
        end
        n_checks++; if (first_c !== 2 || last_c - first_c !== 15) begin
            n_fail++; $display("FAIL full_timing: got first=%0d span=%0d expected 2 15", first_c, last_c - first_c);
        end
    endtask

    task automatic test_wrap;
`ifdef RAM_READER_BOUNDS_CHECK_EN
        send(4'd14, 4'd3);
        @(negedge clk);
        n_checks++; if ({req_err, req_ready, mem_rd_en} !== 3'b100) begin
            n_fail++; $display("FAIL err_t1: got err=%b rdy=%b rd=%b expected 1 0 0", req_err, req_ready, mem_rd_en);
        end
        @(negedge clk);
        n_checks++; if ({req_err, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL err_t2: got err=%b rdy=%b expected 0 1", req_err, req_ready);
        end
        collect(10, 0);
        n_checks++; if (got_n !== 0 || rd_seen !== 0) begin
            n_fail++; $display("FAIL err_quiet: got beats=%0d reads=%0d expected 0 0", got_n, rd_seen);
        end
`else
        logic [7:0] exp [4];
        exp = '{8'h1E, 8'h1F, 8'h10, 8'h11};
        send(4'd14, 4'd3);
        collect(20, 0);
        n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_d[i] !== exp[i] || got_l[i] !== (i == 3)) begin
                n_fail++; $display("FAIL wrap_beat%0d: got d=%h l=%b expected %h %b", i, got_d[i], got_l[i], exp[i], i == 3);
            end
        end
`endif
    endtask

    task automatic test_backpressure;
        send(4'd4, 4'd7);
        collect(80, 1);
        n_checks++; if (got_n !== 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", got_n); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (got_d[i] !== 8'(8'h14 + i) || got_l[i] !== (i == 7)) begin
                n_fail++; $display("FAIL bp_beat%0d: got d=%h l=%b expected %h %b", i, got_d[i], got_l[i], 8'(8'h14 + i), i == 7);
            end
        end
        n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stall_err); end
        n_checks++; if (occ_err !== 0) begin n_fail++; $display("FAIL bp_occupancy: got %0d overissues expected 0", occ_err); end
    endtask

    task automatic test_back_to_back;
        bit seen = 0;
        int early = 0, acc_c = -1, lc = -1, n = 0;
        logic [7:0] d [8];
        logic l [8];
        @(negedge clk);
        req_valid = 1; req_addr = 0; req_len = 3; rsp_ready = 1;
        @(posedge clk);
        #1 req_addr = 5; req_len = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (seen && acc_c < 0) begin
                acc_c = c;
                n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", req_ready); end
            end else if (acc_c < 0 && req_ready) early++;
            if (rsp_valid && rsp_ready) begin
                if (n < 8) begin d[n] = rsp_data; l[n] = rsp_last; end
                n++;
                if (rsp_last && !seen) begin seen = 1; lc = c; end
            end
            if (acc_c == c) begin @(posedge clk); #1 req_valid = 0; end
        end
        req_valid = 0;
        n_checks++; if (early !== 0 || acc_c !== lc + 1 || lc !== 5) begin
            n_fail++; $display("FAIL b2b_accept: got early=%0d accept=%0d last=%0d expected 0 6 5", early, acc_c, lc);
        end
        n_checks++; if (n !== 5 || d[0] !== 8'h10 || d[3] !== 8'h13 || d[4] !== 8'h15 || l[3] !== 1'b1 || l[4] !== 1'b1 || l[2] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_beats: got n=%0d d0=%h d3=%h d4=%h l2=%b l3=%b l4=%b expected 5 10 13 15 0 1 1", n, d[0], d[3], d[4], l[2], l[3], l[4]);
        end
    endtask

    task automatic test_mid_reset;
        int h = 0;
        send(4'd0, 4'd15);
        for (int c = 0; c < 20 && h < 3; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) h++;
        end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        n_checks++; if ({req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_last, busy} !== {1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL midreset_outputs: got rdy=%b rd=%b addr=%h v=%b d=%h l=%b busy=%b", req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_last, busy);
        end
        @(negedge clk); rst_n = 1;
        send(4'd8, 4'd1);
        collect(15, 0);
        n_checks++; if (got_n !== 2 || got_d[0] !== 8'h18 || got_d[1] !== 8'h19 || got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin
            n_fail++; $display("FAIL midreset_beats: got n=%0d d=%h,%h l=%b,%b expected 2 18,19 0,1", got_n, got_d[0], got_d[1], got_l[0], got_l[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);
        test_reset;
        test_single;
        test_full_burst;
        test_wrap;
        test_backpressure;
        test_back_to_back;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
